// File: rtl/sample_dma_writer.sv
// Drains the clk_48 sample FIFO into SDRAM over the write channel, one word in flight at a time.
// Linear buffers stop at the last address; circular buffers wrap back to base.
module sample_dma_writer #(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_data,
    output logic [AW-1:0] awaddr,
    output logic [DW-1:0] wdata,
    output logic          wvalid,
    input  logic          wready,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_len,
    input  logic          cfg_circular,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic          wrapped,
    output logic [AW-1:0] wr_ptr
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, WRITE} state_t;

    state_t        state, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] last_q, last_d;
    logic          circ_q, circ_d;
    logic          stop_pend, stop_pend_d;
    logic [AW-1:0] wr_ptr_d, awaddr_d;
    logic [DW-1:0] wdata_d;
    logic          fifo_rd_d, wvalid_d, busy_d, done_d, wrapped_d;
    logic          finish;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            last_q    <= '0;
            circ_q    <= 1'b0;
            stop_pend <= 1'b0;
            wr_ptr    <= '0;
            awaddr    <= '0;
            wdata     <= '0;
            fifo_rd   <= 1'b0;
            wvalid    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            state     <= state_d;
            base_q    <= base_d;
            last_q    <= last_d;
            circ_q    <= circ_d;
            stop_pend <= stop_pend_d;
            wr_ptr    <= wr_ptr_d;
            awaddr    <= awaddr_d;
            wdata     <= wdata_d;
            fifo_rd   <= fifo_rd_d;
            wvalid    <= wvalid_d;
            busy      <= busy_d;
            done      <= done_d;
            wrapped   <= wrapped_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        base_d    = base_q;
        last_d    = last_q;
        circ_d    = circ_q;
        wr_ptr_d  = wr_ptr;
        awaddr_d  = awaddr;
        wdata_d   = wdata;
        fifo_rd_d = 1'b0;
        wvalid_d  = wvalid;
        busy_d    = busy;
        done_d    = done;
        wrapped_d = wrapped;
        finish    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    wrapped_d = 1'b0;
                    if (cfg_len != '0) begin
                        base_d   = cfg_base;
                        last_d   = cfg_base + cfg_len - AW'(1);
                        circ_d   = cfg_circular;
                        wr_ptr_d = cfg_base;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        state_d  = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (stop_pend || stop) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                // Wait out the cycle the read pulse is on; data is valid the cycle after.
                if (!fifo_rd) begin
                    wdata_d  = fifo_data;
                    awaddr_d = wr_ptr;
                    wvalid_d = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (wready) begin
                    wvalid_d = 1'b0;
                    if (wr_ptr == last_q) begin
                        if (circ_q) begin
                            wr_ptr_d  = base_q;
                            wrapped_d = 1'b1;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr + AW'(1);
                    end
                    if (finish || stop_pend || stop) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop is only remembered while busy and is forgotten on the way back to IDLE
        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
        end else begin
            stop_pend_d = stop_pend || (stop && (state != IDLE));
        end
    end

endmodule

// File: tb/tb_sample_dma_writer.sv
// Directed bench for sample_dma_writer with a small standard-mode FIFO model and a write logger.
module tb_sample_dma_writer;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic [AW-1:0] awaddr;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_len;
    logic          cfg_circular;
    logic          start;
    logic          stop;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [AW-1:0] wr_ptr;

    int checks = 0;
    int errors = 0;

    // FIFO model: initial block pushes, read pulse pops into fifo_data one cycle later
    logic [DW-1:0] mem [64];
    int            wr_idx = 0;
    int            rd_idx = 0;
    assign fifo_empty = (wr_idx == rd_idx);

    // Write and read-pulse logger
    logic [AW-1:0] log_addr [64];
    logic [DW-1:0] log_data [64];
    int            wr_cnt = 0;
    int            rd_cnt = 0;

    logic [AW-1:0] exp_circ [7] = '{24'h10, 24'h11, 24'h12, 24'h10, 24'h11, 24'h12, 24'h10};

    sample_dma_writer #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .fifo_data    (fifo_data),
        .awaddr       (awaddr),
        .wdata        (wdata),
        .wvalid       (wvalid),
        .wready       (wready),
        .cfg_base     (cfg_base),
        .cfg_len      (cfg_len),
        .cfg_circular (cfg_circular),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .done         (done),
        .wrapped      (wrapped),
        .wr_ptr       (wr_ptr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd && (rd_idx != wr_idx)) begin
            fifo_data <= mem[rd_idx[5:0]];
            rd_idx    <= rd_idx + 1;
        end
        if (fifo_rd) rd_cnt <= rd_cnt + 1;
        if (wvalid && wready) begin
            log_addr[wr_cnt[5:0]] <= awaddr;
            log_data[wr_cnt[5:0]] <= wdata;
            wr_cnt                <= wr_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_idx[5:0]] = d;
        wr_idx = wr_idx + 1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic circ);
        cfg_base     = base;
        cfg_len      = len;
        cfg_circular = circ;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done), 32'h1);
    endtask

    task automatic wait_wvalid(input string tag);
        int n = 0;
        while (!wvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(wvalid), 32'h1);
    endtask

    initial begin
        int w0, r0, n;
        logic saw;
        rst = 1'b1; wready = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_base = '0; cfg_len = '0; cfg_circular = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wvalid",  32'(wvalid),  32'h0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_done",    32'(done),    32'h0);
        chk("rst_wrapped", 32'(wrapped), 32'h0);
        chk("rst_wr_ptr",  32'(wr_ptr),  32'h0);
        chk("rst_awaddr",  32'(awaddr),  32'h0);
        chk("rst_wdata",   32'(wdata),   32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Linear fill of four words
        for (int i = 1; i <= 4; i++) push(16'hA000 + 16'(i));
        w0 = wr_cnt; r0 = rd_cnt;
        pulse_start(24'h000100, 24'd4, 1'b0);
        chk("lin_busy", 32'(busy), 32'h1);
        wait_done("lin_done");
        chk("lin_writes", 32'(wr_cnt - w0), 32'd4);
        chk("lin_reads",  32'(rd_cnt - r0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            n = w0 + i;
            chk("lin_addr", 32'(log_addr[n[5:0]]), 32'h100 + 32'(i));
            chk("lin_data", 32'(log_data[n[5:0]]), 32'hA001 + 32'(i));
        end
        chk("lin_idle_busy", 32'(busy),   32'h0);
        chk("lin_wr_ptr",    32'(wr_ptr), 32'h103);

        // Backpressure on the second word
        for (int i = 1; i <= 4; i++) push(16'hA000 + 16'(i));
        w0 = wr_cnt; r0 = rd_cnt;
        wready = 1'b0;
        pulse_start(24'h000100, 24'd4, 1'b0);
        wait_wvalid("bp_first_wvalid");
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        wait_wvalid("bp_second_wvalid");
        n = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("bp_wvalid", 32'(wvalid), 32'h1);
            chk("bp_awaddr", 32'(awaddr), 32'h101);
            chk("bp_wdata",  32'(wdata),  32'hA002);
            @(negedge clk);
        end
        chk("bp_no_read", 32'(rd_cnt - n), 32'd0);
        wready = 1'b1;
        wait_done("bp_done");
        chk("bp_writes", 32'(wr_cnt - w0), 32'd4);

        // Circular wrap, seven samples into a three-word buffer
        for (int i = 1; i <= 7; i++) push(16'hC000 + 16'(i));
        w0 = wr_cnt;
        pulse_start(24'h000010, 24'd3, 1'b1);
        n = 0;
        while ((wr_cnt - w0) < 7 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("circ_writes", 32'(wr_cnt - w0), 32'd7);
        for (int i = 0; i < 7; i++) begin
            n = w0 + i;
            chk("circ_addr", 32'(log_addr[n[5:0]]), 32'(exp_circ[i]));
        end
        chk("circ_wrapped", 32'(wrapped), 32'h1);
        chk("circ_busy",    32'(busy),    32'h1);
        chk("circ_wr_ptr",  32'(wr_ptr),  32'h11);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("circ_stop_done");
        chk("circ_stop_busy", 32'(busy), 32'h0);

        // Empty FIFO for 20 cycles, then one sample lands at base
        w0 = wr_cnt; r0 = rd_cnt;
        pulse_start(24'h000200, 24'd2, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw = saw | wvalid | fifo_rd;
            @(negedge clk);
        end
        chk("empty_quiet", 32'(saw), 32'h0);
        chk("empty_reads", 32'(rd_cnt - r0), 32'd0);
        push(16'hD001);
        n = 0;
        while (wr_cnt == w0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("empty_addr", 32'(log_addr[w0[5:0]]), 32'h200);
        chk("empty_data", 32'(log_data[w0[5:0]]), 32'hD001);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("empty_stop_done");

        // Stop while a write is stalled: the word still completes, nothing more is read
        push(16'hE001);
        push(16'hE002);
        w0 = wr_cnt; r0 = rd_cnt;
        wready = 1'b0;
        pulse_start(24'h000300, 24'd8, 1'b0);
        wait_wvalid("stop_wvalid");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_held_wvalid", 32'(wvalid), 32'h1);
        wready = 1'b1;
        wait_done("stop_done");
        repeat (4) @(negedge clk);
        chk("stop_busy",   32'(busy),         32'h0);
        chk("stop_writes", 32'(wr_cnt - w0),  32'd1);
        chk("stop_reads",  32'(rd_cnt - r0),  32'd1);
        chk("stop_addr",   32'(log_addr[w0[5:0]]), 32'h300);
        chk("stop_data",   32'(log_data[w0[5:0]]), 32'hE001);

        // Reset while a write is pending
        wready = 1'b0;
        pulse_start(24'h000400, 24'd4, 1'b0);
        wait_wvalid("mid_rst_wvalid");
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wvalid", 32'(wvalid), 32'h0);
        chk("mid_rst_busy",   32'(busy),   32'h0);
        chk("mid_rst_done",   32'(done),   32'h0);
        chk("mid_rst_wr_ptr", 32'(wr_ptr), 32'h0);
        rst = 1'b0;
        wready = 1'b1;
        @(negedge clk);

        // Zero length: done without any read or write
        w0 = wr_cnt; r0 = rd_cnt;
        push(16'hF001);
        pulse_start(24'h000500, 24'd0, 1'b0);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
        chk("zero_writes", 32'(wr_cnt - w0), 32'd0);
        chk("zero_reads",  32'(rd_cnt - r0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
